disp_seq_ctrl: RTL and testbench

//  Sequencer for the 4-digit temperature display path. On an update request it steps the display mux:

---
 rtl/disp_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_disp_seq_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/disp_seq_ctrl.sv
// disp_seq_ctrl
//   Sequencer for the 4-digit temperature display path. An update request
//   walks the display mux through change, blank, new, blank, change, commit,
//   blank and finally current. Each dwell phase lasts an exact number of
//   clock cycles (LEN * TICK_DIV).
//
// Ports
//   clk       in   1  system clock, all state on posedge
//   reset     in   1  asynchronous, active-high reset
//   start     in   1  pulse: run the full update sequence (restarts if running)
//   show_now  in   1  pulse: jump straight to showing the current value
//   disp_sel  out  2  display mux: 00 blank, 01 change, 10 new, 11 current
//   commit    out  1  pulse: load new value into current registers
//   done      out  1  pulse: sequence finished normally
//   busy      out  1  high while the sequence is running (states 1..7)
//   phase     out  4  current state code (debug)
module disp_seq_ctrl #(
    parameter int TICK_DIV    = 50,
    parameter int SHOW_TICKS  = 2,
    parameter int BLANK_TICKS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       show_now,
    output logic [1:0] disp_sel,
    output logic       commit,
    output logic       done,
    output logic       busy,
    output logic [3:0] phase
);

    localparam int DIV_MAX = (TICK_DIV > 2) ? TICK_DIV : 2;
    localparam int LEN_MAX0 = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
    localparam int LEN_MAX = (LEN_MAX0 > 2) ? LEN_MAX0 : 2;
    localparam int DIV_W = $clog2(DIV_MAX);
    localparam int DWL_W = $clog2(LEN_MAX);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [DWL_W-1:0] SHOW_LAST  = DWL_W'(SHOW_TICKS - 1);
    localparam logic [DWL_W-1:0] BLANK_LAST = DWL_W'(BLANK_TICKS - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        SHOW_CHG1 = 4'd1,
        BLANK1    = 4'd2,
        SHOW_NEW  = 4'd3,
        BLANK2    = 4'd4,
        SHOW_CHG2 = 4'd5,
        COMMIT    = 4'd6,
        BLANK3    = 4'd7,
        SHOW_CUR  = 4'd8
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DWL_W-1:0] dwell_q, dwell_d;
    logic             done_q, done_d;
    logic             is_show_s;
    logic             is_blank_s;
    logic [DWL_W-1:0] len_last_s;
    state_e           dwell_next_s;

    // State, counters and the done flag; reset drops everything to IDLE at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            dwell_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            dwell_q <= dwell_d;
            done_q  <= done_d;
        end
    end

    // Classify the current dwell state and pick its length and successor.
    always_comb begin
        is_show_s    = 1'b0;
        is_blank_s   = 1'b0;
        dwell_next_s = state_q;
        case (state_q)
            SHOW_CHG1: begin is_show_s  = 1'b1; dwell_next_s = BLANK1;    end
            BLANK1:    begin is_blank_s = 1'b1; dwell_next_s = SHOW_NEW;  end
            SHOW_NEW:  begin is_show_s  = 1'b1; dwell_next_s = BLANK2;    end
            BLANK2:    begin is_blank_s = 1'b1; dwell_next_s = SHOW_CHG2; end
            SHOW_CHG2: begin is_show_s  = 1'b1; dwell_next_s = COMMIT;    end
            BLANK3:    begin is_blank_s = 1'b1; dwell_next_s = SHOW_CUR;  end
            default:   begin dwell_next_s = state_q;                      end
        endcase
        if (is_show_s) begin
            len_last_s = SHOW_LAST;
        end else begin
            len_last_s = BLANK_LAST;
        end
    end

    // Next-state logic; requests override the sequence, show_now beats start.
    always_comb begin
        state_d = state_q;
        div_d   = '0;
        dwell_d = '0;
        done_d  = 1'b0;
        if (show_now) begin
            state_d = SHOW_CUR;
        end else if (start) begin
            state_d = SHOW_CHG1;
        end else if (is_show_s || is_blank_s) begin
            if (div_q == DIV_LAST) begin
                if (dwell_q == len_last_s) begin
                    // Counters restart from zero in the next state.
                    state_d = dwell_next_s;
                    done_d  = (state_q == BLANK3);
                end else begin
                    dwell_d = dwell_q + {{(DWL_W-1){1'b0}}, 1'b1};
                end
            end else begin
                div_d   = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
                dwell_d = dwell_q;
            end
        end else if (state_q == COMMIT) begin
            state_d = BLANK3;
        end else begin
            state_d = state_q;
        end
    end

    // Outputs decode straight from registered state, so they are glitch-free.
    always_comb begin
        case (state_q)
            SHOW_CHG1, SHOW_CHG2: disp_sel = 2'b01;
            SHOW_NEW:             disp_sel = 2'b10;
            SHOW_CUR:             disp_sel = 2'b11;
            default:              disp_sel = 2'b00;
        endcase
        commit = (state_q == COMMIT);
        busy   = (state_q != IDLE) && (state_q != SHOW_CUR);
        done   = done_q;
        phase  = state_q;
    end

endmodule

// File: tb/tb_disp_seq_ctrl.sv
// Testbench for disp_seq_ctrl with TICK_DIV=4, SHOW_TICKS=2, BLANK_TICKS=1.
// The reference model tracks only "cycles since the sequence started" and
// derives the expected outputs from the phase-duration table.
module tb_disp_seq_ctrl;

    localparam int TD    = 4;
    localparam int ST    = 2;
    localparam int BT    = 1;
    localparam int TOTAL = 3 * ST * TD + 3 * BT * TD + 1;

    logic       clk;
    logic       reset;
    logic       start;
    logic       show_now;
    logic [1:0] disp_sel;
    logic       commit;
    logic       done;
    logic       busy;
    logic [3:0] phase;

    int checks;
    int failures;
    int mode;        // 0 idle, 1 running (k = cycles since first SHOW_CHG1), 2 showing current directly
    int k;
    int commit_cnt;

    disp_seq_ctrl #(.TICK_DIV(TD), .SHOW_TICKS(ST), .BLANK_TICKS(BT)) dut (
        .clk(clk), .reset(reset), .start(start), .show_now(show_now),
        .disp_sel(disp_sel), .commit(commit), .done(done), .busy(busy), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t mode=%0d k=%0d)", tag, obs, exp, $time, mode, k);
        end
    endtask

    task automatic expect_all();
        int dur[7];
        int rem;
        bit found;
        int e_ph, e_sel, e_com, e_done, e_busy;
        dur = '{ST*TD, BT*TD, ST*TD, BT*TD, ST*TD, 1, BT*TD};
        e_ph = 0; e_sel = 0; e_com = 0; e_done = 0; e_busy = 0;
        if (mode == 2) begin
            e_ph = 8; e_sel = 3;
        end else if (mode == 1) begin
            if (k < TOTAL) begin
                rem = k;
                found = 1'b0;
                for (int i = 0; i < 7; i++) begin
                    if (!found) begin
                        if (rem < dur[i]) begin
                            e_ph = i + 1;
                            found = 1'b1;
                        end else begin
                            rem -= dur[i];
                        end
                    end
                end
                e_busy = 1;
                e_com  = (e_ph == 6);
                e_sel  = (e_ph == 1 || e_ph == 5) ? 1 : (e_ph == 3) ? 2 : 0;
            end else begin
                e_ph = 8; e_sel = 3; e_done = (k == TOTAL);
            end
        end
        chk("phase", 32'(phase), 32'(e_ph));
        chk("disp_sel", 32'(disp_sel), 32'(e_sel));
        chk("commit", 32'(commit), 32'(e_com));
        chk("done", 32'(done), 32'(e_done));
        chk("busy", 32'(busy), 32'(e_busy));
        if (commit === 1'b1) commit_cnt++;
    endtask

    // One clock: drive requests for the next edge, update model, check at negedge.
    task automatic cycle(input bit s, input bit sn);
        start    = s;
        show_now = sn;
        @(posedge clk);
        if (sn) begin
            mode = 2;
        end else if (s) begin
            mode = 1;
            k = 0;
        end else if (mode == 1 && k <= TOTAL) begin
            k++;
        end
        #1;
        start    = 1'b0;
        show_now = 1'b0;
        @(negedge clk);
        expect_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic async_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        mode = 0;
        k = 0;
        expect_all();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        expect_all();
    endtask

    initial begin
        checks = 0; failures = 0; mode = 0; k = 0; commit_cnt = 0;
        reset = 1'b1; start = 1'b0; show_now = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        expect_all();
        reset = 1'b0;

        // 1. quiet after reset
        idle(100);

        // 2. full sequence, then linger in SHOW_CUR
        cycle(1'b1, 1'b0);
        idle(45);

        // 3. show_now at cycle 10
        cycle(1'b1, 1'b0);
        idle(9);
        cycle(1'b0, 1'b1);
        idle(40);

        // 4. restart at cycle 20, exactly one commit
        commit_cnt = 0;
        cycle(1'b1, 1'b0);
        idle(19);
        cycle(1'b1, 1'b0);
        idle(45);
        chk("restart_commit_count", 32'(commit_cnt), 32'd1);

        // 5. start and show_now together
        cycle(1'b1, 1'b1);
        idle(10);

        // 6. reset at cycle 30
        commit_cnt = 0;
        cycle(1'b1, 1'b0);
        idle(30);
        async_reset();
        idle(50);
        chk("reset_commit_count", 32'(commit_cnt), 32'd0);

        // start arriving in the COMMIT cycle: commit still seen, then restart
        cycle(1'b1, 1'b0);
        idle(32);
        chk("commit_cycle_reached", 32'(commit), 32'd1);
        cycle(1'b1, 1'b0);
        idle(40);

        // randomized requests and occasional resets
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r == 100) begin
                async_reset();
            end else begin
                cycle(r < 4, r >= 196);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
